// File: rtl/sel_decoder_if.sv
// Select-decoder bus: clock enable, mode, select request and the registered one-hot result.
// The err flag is only present when SEL_DECODER_ERR_EN is defined.
interface sel_decoder_if #(
    parameter int IN_W    = 2,
    parameter int NUM_OUT = 4
);
    // Handshake: there is no back-pressure. A request is taken on any enabled rising edge
    // where in_valid=1 in direct mode; out_valid=1 means out was rewritten on the last edge.
    logic               en;
    logic               mode;
    logic [IN_W-1:0]    in;
    logic               in_valid;
    logic [NUM_OUT-1:0] out;
    logic               out_valid;
    logic [1:0]         state;
`ifdef SEL_DECODER_ERR_EN
    logic               err;

    modport master (output en, mode, in, in_valid, input out, out_valid, state, err);
    modport slave  (input en, mode, in, in_valid, output out, out_valid, state, err);
`else
    modport master (output en, mode, in, in_valid, input out, out_valid, state);
    modport slave  (input en, mode, in, in_valid, output out, out_valid, state);
`endif
endinterface

// File: rtl/sel_decoder.sv
// Registered one-hot select decoder with direct-decode and auto-scan modes.
// Define SEL_DECODER_ERR_EN to add the sticky out-of-range err flag.
module sel_decoder #(
    parameter int IN_W    = 2,
    parameter int NUM_OUT = 4
) (
    input logic          clk,
    input logic          rst_n,
    sel_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    cnt_q, cnt_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               ov_q, ov_d;
`ifdef SEL_DECODER_ERR_EN
    logic               err_q, err_d;
`endif

    // Codes at or above NUM_OUT match no bit and decode to all-zero.
    function automatic logic [NUM_OUT-1:0] onehot(input logic [IN_W-1:0] code);
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (code == IN_W'(i)) onehot[i] = 1'b1;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ov_d    = 1'b0;
`ifdef SEL_DECODER_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                out_d = '0;
                if (bus.mode) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    out_d   = onehot('0);
                    ov_d    = 1'b1;
                end else begin
                    state_d = DIRECT;
                end
            end
            DIRECT: begin
                // A mode change wins over a request arriving in the same cycle.
                if (bus.mode) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    out_d   = onehot('0);
                    ov_d    = 1'b1;
                end else if (bus.in_valid) begin
                    out_d = onehot(bus.in);
                    ov_d  = 1'b1;
`ifdef SEL_DECODER_ERR_EN
                    err_d = err_q | (out_d == '0);
`endif
                end
            end
            SCAN: begin
                if (!bus.mode) begin
                    state_d = DIRECT;
                end else begin
                    cnt_d = (cnt_q == IN_W'(NUM_OUT - 1)) ? '0 : cnt_q + IN_W'(1);
                    out_d = onehot(cnt_d);
                    ov_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
`ifdef SEL_DECODER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else if (bus.en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
`ifdef SEL_DECODER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = ov_q;
    assign bus.state     = state_q;
`ifdef SEL_DECODER_ERR_EN
    assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_sel_decoder.sv
// Bench for sel_decoder: two instances (IN_W=2/NUM_OUT=4 and IN_W=3/NUM_OUT=5) checked every
// cycle against a behavioural model, plus directed literal checks of the key scenarios.
module tb_sel_decoder;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sel_decoder_if #(.IN_W(2), .NUM_OUT(4)) ia ();
    sel_decoder_if #(.IN_W(3), .NUM_OUT(5)) ib ();

    sel_decoder #(.IN_W(2), .NUM_OUT(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    sel_decoder #(.IN_W(3), .NUM_OUT(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = idle, 1 = direct decode, 2 = scanning; pos is the scan position.
    int         m_phase[2] = '{0, 0};
    int         m_pos[2]   = '{0, 0};
    logic [7:0] m_out[2]   = '{8'd0, 8'd0};
    logic       m_ov[2]    = '{1'b0, 1'b0};
    logic       m_err[2]   = '{1'b0, 1'b0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_pos[k] = 0; m_out[k] = 8'd0; m_ov[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic start_scan(input int k);
        m_phase[k] = 2; m_pos[k] = 0; m_out[k] = 8'd1; m_ov[k] = 1'b1;
    endtask

    task automatic model_step(input int k, input int num_out, input logic en,
                              input logic mode, input int code, input logic vld);
        if (!en) return;
        if (m_phase[k] == 0) begin
            if (mode) start_scan(k);
            else begin m_phase[k] = 1; m_ov[k] = 1'b0; end
        end else if (m_phase[k] == 1) begin
            if (mode) start_scan(k);
            else if (vld) begin
                m_ov[k] = 1'b1;
                if (code < num_out) m_out[k] = 8'(1 << code);
                else begin m_out[k] = 8'd0; m_err[k] = 1'b1; end
            end else m_ov[k] = 1'b0;
        end else begin
            if (mode) begin
                m_pos[k] = (m_pos[k] + 1) % num_out;
                m_out[k] = 8'(1 << m_pos[k]);
                m_ov[k]  = 1'b1;
            end else begin
                m_phase[k] = 1; m_ov[k] = 1'b0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0, 4, ia.en, ia.mode, int'(ia.in), ia.in_valid);
            model_step(1, 5, ib.en, ib.mode, int'(ib.in), ib.in_valid);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        lit("a_out", 8'(ia.out), m_out[0]);
        lit("a_out_valid", 8'(ia.out_valid), 8'(m_ov[0]));
        lit("a_onehot", 8'($countones(ia.out) <= 1), 8'd1);
        lit("b_out", 8'(ib.out), m_out[1]);
        lit("b_out_valid", 8'(ib.out_valid), 8'(m_ov[1]));
        lit("b_onehot", 8'($countones(ib.out) <= 1), 8'd1);
`ifdef SEL_DECODER_ERR_EN
        lit("a_err", 8'(ia.err), 8'(m_err[0]));
        lit("b_err", 8'(ib.err), 8'(m_err[1]));
`endif
    end

    // ---------------- stimulus ----------------
    logic [7:0] exp_dir[4]  = '{8'h01, 8'h02, 8'h04, 8'h08};
    logic [7:0] exp_scan[7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h01, 8'h02};

    initial begin
        ia.en = 1'b0; ia.mode = 1'b0; ia.in = '0; ia.in_valid = 1'b0;
        ib.en = 1'b0; ib.mode = 1'b0; ib.in = '0; ib.in_valid = 1'b0;
        tick();
        lit("rst_a_out", 8'(ia.out), 8'd0);
        lit("rst_a_ov", 8'(ia.out_valid), 8'd0);
        lit("rst_a_state", 8'(ia.state), 8'd0);
        lit("rst_b_out", 8'(ib.out), 8'd0);
        rst_n = 1'b1;

        // IDLE -> DIRECT on both
        ia.en = 1'b1; ib.en = 1'b1;
        tick();
        lit("idle_to_direct_ov", 8'(ia.out_valid), 8'd0);

        // walk every code on A; out-of-range then in-range request on B
        for (int i = 0; i < 4; i++) begin
            ia.in = 2'(i); ia.in_valid = 1'b1;
            if (i == 0) begin ib.in = 3'd6; ib.in_valid = 1'b1; end
            else if (i == 1) begin ib.in = 3'd2; ib.in_valid = 1'b1; end
            else ib.in_valid = 1'b0;
            tick();
            lit("dir_a_out", 8'(ia.out), exp_dir[i]);
            lit("dir_a_ov", 8'(ia.out_valid), 8'd1);
            if (i == 0) begin
                lit("oor_b_out", 8'(ib.out), 8'd0);
                lit("oor_b_ov", 8'(ib.out_valid), 8'd1);
`ifdef SEL_DECODER_ERR_EN
                lit("oor_b_err", 8'(ib.err), 8'd1);
`endif
            end else if (i == 1) begin
                lit("after_oor_b_out", 8'(ib.out), 8'h04);
`ifdef SEL_DECODER_ERR_EN
                lit("sticky_b_err", 8'(ib.err), 8'd1);
`endif
            end
        end

        // A parks on 0100; B scans with wrap at NUM_OUT
        ia.in = 2'd2; ia.in_valid = 1'b1;
        ib.mode = 1'b1; ib.in_valid = 1'b1; ib.in = 3'd7;
        for (int i = 0; i < 7; i++) begin
            tick();
            ia.in_valid = 1'b0;
            lit("scan_b_out", 8'(ib.out), exp_scan[i]);
            lit("scan_b_ov", 8'(ib.out_valid), 8'd1);
        end
        tick();
        lit("scan_b_cnt2", 8'(ib.out), 8'h04);
        ib.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("hold_b_out", 8'(ib.out), 8'h04);
        end
        ib.en = 1'b1;
        tick();
        lit("resume_b_out", 8'(ib.out), 8'h08);
        lit("park_a_out", 8'(ia.out), 8'h04);
        lit("park_a_ov", 8'(ia.out_valid), 8'd0);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        lit("async_a_out", 8'(ia.out), 8'd0);
        lit("async_a_ov", 8'(ia.out_valid), 8'd0);
        lit("async_b_out", 8'(ib.out), 8'd0);
`ifdef SEL_DECODER_ERR_EN
        lit("async_b_err", 8'(ib.err), 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        ia.mode = 1'b1;
        ib.mode = 1'b0;
        tick();
        lit("post_rst_a_scan", 8'(ia.out), 8'h01);
        lit("post_rst_a_ov", 8'(ia.out_valid), 8'd1);

        // mode change beats a same-cycle request
        ia.mode = 1'b0;
        tick();
        ia.in = 2'd1; ia.in_valid = 1'b1;
        tick();
        lit("pre_switch_a_out", 8'(ia.out), 8'h02);
        ia.mode = 1'b1; ia.in = 2'd3; ia.in_valid = 1'b1;
        tick();
        lit("switch_a_out", 8'(ia.out), 8'h01);
        lit("switch_a_ov", 8'(ia.out_valid), 8'd1);

        // randomized traffic with rare mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            ia.en = ($urandom_range(0, 9) != 0);
            ib.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) ia.mode = ~ia.mode;
            if ($urandom_range(0, 7) == 0) ib.mode = ~ib.mode;
            ia.in = 2'($urandom_range(0, 3));
            ib.in = 3'($urandom_range(0, 7));
            ia.in_valid = 1'($urandom_range(0, 1));
            ib.in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sel_decoder.md
SEL_DECODER -- requirements
Module: sel_decoder

Interface
REQ-001 Parameter IN_W, default 2: select input width, range 1..6.
REQ-002 Parameter NUM_OUT, default 4: number of one-hot outputs, range 2..2**IN_W.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset, asynchronous assert, active-low; all state cleared while low.
REQ-005 EN  input  1: clock enable; low freezes every register.
REQ-006 MODE  input  1: 0 = direct decode, 1 = auto-scan.
REQ-007 IN  input  IN_W: select code, used in direct mode.
REQ-008 IN_VALID  input  1: IN is valid this cycle (direct mode only).
REQ-009 OUT  output  NUM_OUT: registered one-hot or all-zero select vector.
REQ-010 OUT_VALID  output  1: OUT was updated from a valid request or scan step this cycle.
REQ-011 ERR  output  1: sticky out-of-range flag; present only with SEL_DECODER_ERR_EN.

Function
REQ-012 Block SHALL implement FSM states IDLE, DIRECT and SCAN, with state register reset to IDLE.
REQ-013 With EN=1, IDLE SHALL go to DIRECT when MODE=0 and to SCAN when MODE=1.
REQ-014 With EN=1, DIRECT/SCAN SHALL go to the other state when MODE differs from the current state, transition taking effect next edge.
REQ-015 With EN=0, state, OUT, OUT_VALID, scan counter and ERR SHALL hold.
REQ-016 DIRECT, EN=1, IN_VALID=1, IN<NUM_OUT: next edge OUT SHALL equal only bit IN set, OUT_VALID=1 (latency 1 cycle).
REQ-017 DIRECT, EN=1, IN_VALID=1, IN>=NUM_OUT: next edge OUT SHALL be all-zero, OUT_VALID=1.
REQ-018 DIRECT, EN=1, IN_VALID=0: OUT SHALL hold, OUT_VALID SHALL be 0.
REQ-019 SCAN: scan counter (width IN_W) SHALL clear to 0 on the edge entering SCAN; OUT SHALL show bit 0 that same edge.
REQ-020 SCAN, EN=1: each subsequent edge counter SHALL increment and OUT SHALL show the new counter bit; OUT_VALID=1 every SCAN cycle.
REQ-021 Counter SHALL wrap from NUM_OUT-1 to 0 (not 2**IN_W-1), so OUT never shows an all-zero vector in SCAN.
REQ-022 IN and IN_VALID SHALL be ignored in SCAN and IDLE.
REQ-023 IDLE: OUT all-zero, OUT_VALID=0.
REQ-024 OUT SHALL never have more than one bit set in any cycle.
REQ-025 Mode change and valid request in the same cycle: FSM transition has priority; request from the old mode is dropped.

Reset
REQ-026 RST low SHALL immediately force state=IDLE, OUT=0, OUT_VALID=0, counter=0, ERR=0, independent of CLK and EN.
REQ-027 Reset mid-scan or mid-request SHALL discard that operation; first edge after RST release with EN=1 follows REQ-013.

Configuration
REQ-028 Macro SEL_DECODER_ERR_EN defined: ERR port exists; ERR SHALL set on the edge of any REQ-017 event and stay 1 until reset.
REQ-029 Macro undefined: ERR port and logic SHALL be absent; REQ-017 behaviour unchanged.

Verification
REQ-030 IN_W=2, NUM_OUT=4, direct: IN=0,1,2,3 with IN_VALID=1 on successive cycles -> OUT=0001,0010,0100,1000 one cycle later, OUT_VALID=1 each.
REQ-031 IN_W=3, NUM_OUT=5, direct: IN=6 valid -> OUT=00000, OUT_VALID=1, ERR=1 next edge and still 1 after a following valid IN=2 (OUT=00100).
REQ-032 IN_W=3, NUM_OUT=5, MODE=1 for 7 cycles -> OUT=00001,00010,00100,01000,10000,00001,00010.
REQ-033 Scan at counter=2, EN=0 for 3 cycles -> OUT stays 00100; EN=1 -> 01000 next edge.
REQ-034 Direct, OUT=0100; RST low between edges -> OUT=0000, OUT_VALID=0 before next edge; release, MODE=1 -> OUT=0001 first enabled edge.
REQ-035 Direct, MODE 0->1 with IN_VALID=1, IN=3 same cycle -> next edge OUT=0001 (scan start), request dropped.
